// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
//   Output bundle of the raster timing generator. The generator drives it
//   through the master modport; the PPU/framebuffer fetch path and the
//   DAC/HDMI encoder consume it through the slave modport.
//
//   Signals (CW = counter/position width):
//     fetch_x, fetch_y  [CW]  position the read path should fetch now
//     fetch_valid       1     fetch position lies in the active area
//     x_pos, y_pos      [CW]  position currently being displayed
//     valid             1     display position lies in the active area
//     hsync, vsync      1     sync outputs, already at the configured polarity
//     line_start        1     one-clk strobe with the update that shows x_pos=0
//     frame_start       1     one-clk strobe with the update that shows (0,0)
//
//   Handshake: this is a free-running stream with no backpressure. valid
//   qualifies x_pos/y_pos and fetch_valid qualifies fetch_x/fetch_y on every
//   clk; there is no ready, so a consumer must accept each update as it comes.
// ---------------------------------------------------------------------------
interface vga_timing_if #(
  parameter int CW = 10
);
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;
  logic          fetch_valid;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic          valid;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;

  modport master (
    output fetch_x, fetch_y, fetch_valid,
    output x_pos, y_pos, valid,
    output hsync, vsync, line_start, frame_start
  );

  modport slave (
    input fetch_x, fetch_y, fetch_valid,
    input x_pos, y_pos, valid,
    input hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. Two free-running counters walk the
//   raster (active, front porch, sync, back porch) one pixel per pix_ce tick.
//   The counter position is published as the fetch position; the same
//   position, delayed by LOOKAHEAD ticks, is published as the display
//   position together with valid, hsync, vsync and the start strobes.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     pix_ce   in   pixel tick; all state advances only on clk edges with it high
//     en       in   run enable; low on a tick parks everything at frame start
//     vif      vga_timing_if.master, all outputs (see the interface file)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int CW        = 10,
  parameter int LOOKAHEAD = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pix_ce,
  input  logic         en,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Elaboration-time parameter checks.
  if (LOOKAHEAD < 0 || LOOKAHEAD > 4) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be in 0..4");
  end
  if (H_TOTAL < 1 || H_TOTAL > (2 ** CW)) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL must be 1..2**CW");
  end
  if (V_TOTAL < 1 || V_TOTAL > (2 ** CW)) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL must be 1..2**CW");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Region bounds are one bit wider than the counters so a bound equal to
  // 2**CW still compares correctly against a zero-extended counter.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  // One pipeline slot: a raster position with everything the display side
  // needs already decoded, so the display outputs come straight from flops.
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          act;   // inside the active area
    logic          hs;    // hsync level (polarity applied)
    logic          vs;    // vsync level (polarity applied)
    logic          sol;   // x == 0
    logic          sof;   // x == 0 and y == 0
  } stage_t;

  // An empty slot carries exactly the reset output values, so an unfilled
  // pipeline needs no separate valid bit to mask the outputs.
  localparam stage_t IDLE = '{
    x:   '0,
    y:   '0,
    act: 1'b0,
    hs:  ~HS_ON,
    vs:  ~VS_ON,
    sol: 1'b0,
    sof: 1'b0
  };

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  stage_t        stage_in;
  // Slot 0 is the fetch position; slot LOOKAHEAD is the display position.
  stage_t        pipe_q [LOOKAHEAD+1];
  stage_t        pipe_d [LOOKAHEAD+1];
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Decode the counter position into a pipeline slot.
  always_comb begin
    stage_in     = IDLE;
    stage_in.x   = hc_q;
    stage_in.y   = vc_q;
    stage_in.act = ({1'b0, hc_q} < H_ACT_END) && ({1'b0, vc_q} < V_ACT_END);
    stage_in.hs  = (({1'b0, hc_q} >= H_SYNC_BEG) && ({1'b0, hc_q} < H_SYNC_END))
                   ? HS_ON : ~HS_ON;
    stage_in.vs  = (({1'b0, vc_q} >= V_SYNC_BEG) && ({1'b0, vc_q} < V_SYNC_END))
                   ? VS_ON : ~VS_ON;
    stage_in.sol = (hc_q == '0);
    stage_in.sof = (hc_q == '0) && (vc_q == '0);
  end

  // Raster counters: they hold the position the next tick will publish.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce) begin
      if (!en) begin
        hc_d = '0;
        vc_d = '0;
      end else if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Pipeline shift and strobe generation.
  always_comb begin
    for (int k = 0; k <= LOOKAHEAD; k++) begin
      pipe_d[k] = pipe_q[k];
    end
    if (pix_ce) begin
      if (!en) begin
        for (int k = 0; k <= LOOKAHEAD; k++) begin
          pipe_d[k] = IDLE;
        end
      end else begin
        pipe_d[0] = stage_in;
        for (int k = 1; k <= LOOKAHEAD; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end
    // Gated by pix_ce so a strobe never outlives the clk of its own tick,
    // no matter how sparse the ticks are.
    line_start_d  = pix_ce & pipe_d[LOOKAHEAD].sol;
    frame_start_d = pix_ce & pipe_d[LOOKAHEAD].sof;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      for (int k = 0; k <= LOOKAHEAD; k++) begin
        pipe_q[k] <= IDLE;
      end
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      for (int k = 0; k <= LOOKAHEAD; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign vif.fetch_x     = pipe_q[0].x;
  assign vif.fetch_y     = pipe_q[0].y;
  assign vif.fetch_valid = pipe_q[0].act;
  assign vif.x_pos       = pipe_q[LOOKAHEAD].x;
  assign vif.y_pos       = pipe_q[LOOKAHEAD].y;
  assign vif.valid       = pipe_q[LOOKAHEAD].act;
  assign vif.hsync       = pipe_q[LOOKAHEAD].hs;
  assign vif.vsync       = pipe_q[LOOKAHEAD].vs;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two small modes run side by side from the same clk/pix_ce/en/reset_n:
//     dut0: H 4/1/1/1 (7 px), V 2/1/1/1 (5 lines), LOOKAHEAD=0, active-low syncs
//     dut2: H 5/2/3/2 (12 px), V 3/2/2/1 (8 lines), LOOKAHEAD=2, active-high syncs
//   The expected outputs come from a raster formula driven by the number of
//   enabled ticks since reset/enable, plus hand-computed directed points.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce  = 1'b0;
  logic en      = 1'b0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(4)) if0 ();
  vga_timing_if #(.CW(4)) if2 ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0), .CW(4), .LOOKAHEAD(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .en(en), .vif(if0)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .CW(4), .LOOKAHEAD(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .en(en), .vif(if2)
  );

  int   checks = 0;
  int   errors = 0;
  int   t      = 0;     // enabled ticks since reset / en re-assert
  logic fresh  = 1'b0;  // last clk edge was a tick

  logic [21:0] obs0, obs2;
  assign obs0 = {if0.fetch_x, if0.fetch_y, if0.fetch_valid, if0.x_pos, if0.y_pos,
                 if0.valid, if0.hsync, if0.vsync, if0.line_start, if0.frame_start};
  assign obs2 = {if2.fetch_x, if2.fetch_y, if2.fetch_valid, if2.x_pos, if2.y_pos,
                 if2.valid, if2.hsync, if2.vsync, if2.line_start, if2.frame_start};

  // Expected output vector for a mode after tt enabled ticks.
  function automatic logic [21:0] model(int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb,
                                        int la, int hp, int vp, int tt, logic fr);
    int   ht, vt, i, fx, fy, dx, dy;
    logic hon, von, fv, dv, hs, vs, ls, fs;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    hon = (hp != 0);
    von = (vp != 0);
    fx = 0; fy = 0; dx = 0; dy = 0;
    fv = 1'b0; dv = 1'b0; ls = 1'b0; fs = 1'b0;
    hs = ~hon; vs = ~von;
    if (tt >= 1) begin
      i  = tt - 1;
      fx = i % ht;
      fy = (i / ht) % vt;
      fv = (fx < ha) && (fy < va);
    end
    if (tt >= la + 1) begin
      i  = tt - 1 - la;
      dx = i % ht;
      dy = (i / ht) % vt;
      dv = (dx < ha) && (dy < va);
      hs = (dx >= ha + hf && dx < ha + hf + hsw) ? hon : ~hon;
      vs = (dy >= va + vf && dy < va + vf + vsw) ? von : ~von;
      ls = fr && (dx == 0);
      fs = fr && (dx == 0) && (dy == 0);
    end
    return {fx[3:0], fy[3:0], fv, dx[3:0], dy[3:0], dv, hs, vs, ls, fs};
  endfunction

  function automatic logic [21:0] exp0();
    return model(4, 1, 1, 1, 2, 1, 1, 1, 0, 0, 0, t, fresh);
  endfunction

  function automatic logic [21:0] exp2();
    return model(5, 2, 3, 2, 3, 2, 2, 1, 2, 1, 1, t, fresh);
  endfunction

  // One clk edge with the given pix_ce; outputs are settled on return.
  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    if (!reset_n) t = 0;
    else if (ce)  t = en ? t + 1 : 0;
    fresh = ce && reset_n;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    step(1'b1);
    step(1'b1);
    checks += 4;
    if (obs0 !== exp0()) begin
      errors++; $display("FAIL reset dut0 got %h exp %h", obs0, exp0());
    end
    if (obs2 !== exp2()) begin
      errors++; $display("FAIL reset dut2 got %h exp %h", obs2, exp2());
    end
    if ({if0.hsync, if0.vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_sync_lo got %b exp 11", {if0.hsync, if0.vsync});
    end
    if ({if2.hsync, if2.vsync} !== 2'b00) begin
      errors++; $display("FAIL reset_sync_hi got %b exp 00", {if2.hsync, if2.vsync});
    end
  endtask

  // Two full tiny frames with pix_ce always high, plus the fill of dut2.
  task automatic test_frames();
    int ls_cnt, fs_cnt;
    ls_cnt = 0; fs_cnt = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step(1'b1);
      ls_cnt += int'(if0.line_start);
      fs_cnt += int'(if0.frame_start);
      checks += 2;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL frames dut0 t=%0d got %h exp %h", t, obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL frames dut2 t=%0d got %h exp %h", t, obs2, exp2());
      end
      if (t == 2) begin
        checks++;
        if ({if2.valid, if2.frame_start} !== 2'b00) begin
          errors++; $display("FAIL fill_t2 got %b exp 00", {if2.valid, if2.frame_start});
        end
      end
      if (t == 3) begin
        checks++;
        if ({if2.x_pos, if2.y_pos, if2.valid, if2.line_start, if2.frame_start} !== 11'b0000_0000_111) begin
          errors++; $display("FAIL fill_t3 got x=%0d y=%0d v=%b ls=%b fs=%b exp 0 0 1 1 1",
                             if2.x_pos, if2.y_pos, if2.valid, if2.line_start, if2.frame_start);
        end
      end
      if (t == 6) begin
        checks++;
        if ({if0.x_pos, if0.hsync} !== {4'd5, 1'b0}) begin
          errors++; $display("FAIL tiny_hsync got x=%0d hs=%b exp x=5 hs=0", if0.x_pos, if0.hsync);
        end
      end
      if (t == 22) begin
        checks++;
        if ({if0.x_pos, if0.y_pos, if0.vsync} !== {4'd0, 4'd3, 1'b0}) begin
          errors++; $display("FAIL tiny_vsync got x=%0d y=%0d vs=%b exp 0 3 0",
                             if0.x_pos, if0.y_pos, if0.vsync);
        end
      end
    end
    checks += 2;
    if (ls_cnt !== 10) begin
      errors++; $display("FAIL line_start_count got %0d exp 10", ls_cnt);
    end
    if (fs_cnt !== 2) begin
      errors++; $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
    end
  endtask

  // dut2 frame wrap: fetch at (0,0) while display is two pixels behind.
  task automatic test_lookahead_wrap();
    while (t < 97) begin
      step(1'b1);
      checks += 2;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL wrap dut0 t=%0d got %h exp %h", t, obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL wrap dut2 t=%0d got %h exp %h", t, obs2, exp2());
      end
    end
    checks++;
    if ({if2.fetch_x, if2.fetch_y, if2.x_pos, if2.y_pos, if2.valid} !== {4'd0, 4'd0, 4'd10, 4'd7, 1'b0}) begin
      errors++; $display("FAIL wrap_point got f=(%0d,%0d) d=(%0d,%0d) v=%b exp f=(0,0) d=(10,7) v=0",
                         if2.fetch_x, if2.fetch_y, if2.x_pos, if2.y_pos, if2.valid);
    end
  endtask

  // pix_ce high one clk in three: holds between ticks, one-clk strobes.
  task automatic test_sparse_ce();
    int strobe_clks;
    strobe_clks = 0;
    for (int k = 0; k < 90; k++) begin
      step((k % 3) == 0);
      if (!fresh) strobe_clks += int'(if0.line_start | if2.line_start);
      checks += 2;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL sparse dut0 k=%0d got %h exp %h", k, obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL sparse dut2 k=%0d got %h exp %h", k, obs2, exp2());
      end
    end
    checks++;
    if (strobe_clks !== 0) begin
      errors++; $display("FAIL sparse_strobe_len got %0d exp 0", strobe_clks);
    end
  endtask

  // Reset asserted mid-cycle while dut2 sits in hsync and vsync.
  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (((t - 3) % 96) != 68 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    checks += 2;
    if (guard >= 200) begin
      errors++; $display("FAIL async_reset_reach got %0d steps exp <200", guard);
    end
    if ({if2.x_pos, if2.y_pos, if2.hsync, if2.vsync} !== {4'd8, 4'd5, 2'b11}) begin
      errors++; $display("FAIL pre_reset got x=%0d y=%0d hs=%b vs=%b exp 8 5 1 1",
                         if2.x_pos, if2.y_pos, if2.hsync, if2.vsync);
    end
    #2;
    reset_n = 1'b0;
    t       = 0;
    fresh   = 1'b0;
    #1;
    checks += 2;
    if (obs0 !== exp0()) begin
      errors++; $display("FAIL async_reset dut0 got %h exp %h", obs0, exp0());
    end
    if (obs2 !== exp2()) begin
      errors++; $display("FAIL async_reset dut2 got %h exp %h", obs2, exp2());
    end
    step(1'b1);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      checks += 3;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL post_reset dut0 t=%0d got %h exp %h", t, obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL post_reset dut2 t=%0d got %h exp %h", t, obs2, exp2());
      end
      if (if2.frame_start !== (k == 3)) begin
        errors++; $display("FAIL post_reset_fs tick=%0d got %b exp %b", k, if2.frame_start, (k == 3));
      end
    end
  endtask

  // en low mid-line: a non-tick clk holds, a tick parks, re-enable restarts.
  task automatic test_enable();
    logic [21:0] held0;
    for (int k = 0; k < 10; k++) step(1'b1);
    held0 = obs0;
    en = 1'b0;
    step(1'b0);
    checks++;
    if (obs0 !== {held0[21:2], 2'b00}) begin
      errors++; $display("FAIL en_hold got %h exp %h", obs0, {held0[21:2], 2'b00});
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      checks += 3;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL en_off dut0 got %h exp %h", obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL en_off dut2 got %h exp %h", obs2, exp2());
      end
      if ({if2.x_pos, if2.hsync, if2.vsync} !== {4'd0, 2'b00}) begin
        errors++; $display("FAIL en_off_idle got x=%0d hs=%b vs=%b exp 0 0 0",
                           if2.x_pos, if2.hsync, if2.vsync);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(1'b1);
      checks += 2;
      if (obs0 !== exp0()) begin
        errors++; $display("FAIL en_on dut0 t=%0d got %h exp %h", t, obs0, exp0());
      end
      if (obs2 !== exp2()) begin
        errors++; $display("FAIL en_on dut2 t=%0d got %h exp %h", t, obs2, exp2());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_lookahead_wrap();
    test_sparse_ce();
    test_async_reset();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
